qif_spike_decoder: RTL

Receive-side decoder for the spike train produced by the QIF neuron. It turns the neuron's 1-bit spike output back into numbers by measuring the inter-spike interval (ISI) between consecutive rising edges and the spike count over a fixed window. The ISI is delivered over a valid/ready handshake. The rate is delivered as a one-cycle pulse at each window end. It sits downstream of the neuron's spike output and feeds the readout/host logic.

---
 rtl/qif_spike_decoder_if.sv | 53 +++++
 rtl/qif_spike_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qif_spike_decoder_if.sv
// -----------------------------------------------------------------------------
// qif_spike_decoder_if
//
// Bundles the outputs of the QIF spike decoder and the ISI consumer's ready
// back-pressure into a single interface.
//
// Parameters:
//   ISI_W  width of the inter-spike interval sample
//   CNT_W  width of the spike-count (rate) sample
//
// Signals:
//   isi_data    captured interval in cycles (decoder -> consumer)
//   isi_valid   isi_data holds an unconsumed sample (decoder -> consumer)
//   isi_ready   consumer accepts the sample (consumer -> decoder)
//   rate_data   spike count of the last completed window (decoder -> consumer)
//   rate_valid  one-cycle pulse when rate_data updates (decoder -> consumer)
//   overrun     sticky flag, an ISI sample was dropped (decoder -> consumer)
//
// Modports:
//   master  the decoder side
//   slave   the readout / host side
// -----------------------------------------------------------------------------
interface qif_spike_decoder_if #(
  parameter int ISI_W = 16,
  parameter int CNT_W = 8
);

  logic [ISI_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready;
  logic [CNT_W-1:0] rate_data;
  logic             rate_valid;
  logic             overrun;

  modport master (
    output isi_data,
    output isi_valid,
    input  isi_ready,
    output rate_data,
    output rate_valid,
    output overrun
  );

  modport slave (
    input  isi_data,
    input  isi_valid,
    output isi_ready,
    input  rate_data,
    input  rate_valid,
    input  overrun
  );

endinterface

// File: rtl/qif_spike_decoder.sv
// -----------------------------------------------------------------------------
// qif_spike_decoder
//
// Receive-side decoder for the 1-bit spike train of the QIF neuron. Two
// measurements are recovered from the spike level:
//   * the inter-spike interval (ISI) between consecutive accepted rising
//     edges, delivered over a valid/ready handshake, and
//   * the spike count over a fixed window of 2^WIN_LOG2 enabled cycles,
//     delivered as a one-cycle rate_valid pulse at each window end.
//
// Parameters:
//   ISI_W     ISI counter / sample width, saturates at 2^ISI_W-1
//   CNT_W     spike-count width, saturates at 2^CNT_W-1
//   WIN_LOG2  rate window length is 2^WIN_LOG2 enabled cycles
//   REFRACT   refractory length in cycles (refractory build only)
//
// Ports:
//   clk       single clock, all state on the rising edge
//   rst       asynchronous, active-high reset
//   en        decoder enable; low disarms and clears the counters
//   spike_in  spike level from the neuron, synchronous to clk
//   dec_if    qif_spike_decoder_if.master: isi_data/isi_valid/isi_ready,
//             rate_data/rate_valid and the sticky overrun flag
//
// Build option:
//   QIF_DECODER_REFRACT_EN  when defined, edges arriving within REFRACT-1
//                           cycles after an accepted edge are ignored
//                           entirely (no ISI restart, no count, no FSM
//                           change). When undefined every edge is accepted.
// -----------------------------------------------------------------------------
module qif_spike_decoder #(
  parameter int ISI_W    = 16,
  parameter int CNT_W    = 8,
  parameter int WIN_LOG2 = 10,
  parameter int REFRACT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 spike_in,
  qif_spike_decoder_if.master  dec_if
);

  localparam logic [ISI_W-1:0]    ISI_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  // Refractory down-counter only ever holds REFRACT-1.
  localparam int REF_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  typedef enum logic {
    ST_DISARMED,
    ST_ARMED
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_reg;
  logic                spike_d_reg;
  logic [ISI_W-1:0]    isi_c_reg;
  logic [ISI_W-1:0]    isi_data_reg;
  logic                isi_valid_reg;
  logic                overrun_reg;
  logic [WIN_LOG2-1:0] win_reg;
  logic [CNT_W-1:0]    n_reg;
  logic [CNT_W-1:0]    rate_data_reg;
  logic                rate_valid_reg;
  logic [REF_W-1:0]    refract_cnt;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             edge_raw;
  logic             refract_block;
  logic             edge_acc;
  logic             handshake;
  logic [ISI_W-1:0] isi_c_next;
  logic [CNT_W:0]   n_plus;
  logic [CNT_W-1:0] n_sat_next;

  // The edge detector keeps running while disabled so that a spike level
  // already high when en rises is not mistaken for a fresh edge.
  assign edge_raw      = spike_in & ~spike_d_reg;
  assign refract_block = |refract_cnt;
  assign edge_acc      = en & edge_raw & ~refract_block;
  assign handshake     = isi_valid_reg & dec_if.isi_ready;

  // ISI counter: restarts at 1 on an accepted edge so that edges at t0 and
  // t1 leave exactly t1-t0 in the counter at t1; sticks at all-ones.
  always_comb begin
    isi_c_next = isi_c_reg;
    if (!en) begin
      isi_c_next = '0;
    end else if (edge_acc) begin
      isi_c_next = ISI_W'(1);
    end else if (isi_c_reg != ISI_MAX) begin
      isi_c_next = isi_c_reg + ISI_W'(1);
    end
  end

  // Saturating count including an edge in the current cycle; used both for
  // the running count and for the closing value at the window terminal
  // count, so an edge on the terminal cycle lands in the closing window.
  assign n_plus     = {1'b0, n_reg} + {{CNT_W{1'b0}}, edge_acc};
  assign n_sat_next = n_plus[CNT_W] ? CNT_MAX : n_plus[CNT_W-1:0];

  // ---------------------------------------------------------------------------
  // Edge detector delay register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_d_reg <= 1'b0;
    end else begin
      spike_d_reg <= spike_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Refractory window
  // ---------------------------------------------------------------------------
`ifdef QIF_DECODER_REFRACT_EN
  localparam logic [REF_W-1:0] REF_HOLD = REF_W'((REFRACT > 1) ? REFRACT - 1 : 0);

  // Loaded on an accepted edge, edges are blocked while it is non-zero, so
  // the next edge can be accepted REFRACT cycles after the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refract_cnt <= '0;
    end else if (!en) begin
      refract_cnt <= '0;
    end else if (edge_acc) begin
      refract_cnt <= REF_HOLD;
    end else if (refract_cnt != '0) begin
      refract_cnt <= refract_cnt - REF_W'(1);
    end
  end
`else
  assign refract_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // ISI counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_c_reg <= '0;
    end else begin
      isi_c_reg <= isi_c_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Arm / capture FSM with the ISI output register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_DISARMED;
      isi_data_reg  <= '0;
      isi_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      // A consumed sample clears valid unless a capture below refills it.
      // This also completes a pending handshake while en is low.
      if (handshake) begin
        isi_valid_reg <= 1'b0;
      end

      if (!en) begin
        state_reg <= ST_DISARMED;
      end else if (edge_acc) begin
        case (state_reg)
          ST_DISARMED: begin
            // First edge only establishes the time reference.
            state_reg <= ST_ARMED;
          end
          ST_ARMED: begin
            if (!isi_valid_reg || handshake) begin
              isi_data_reg  <= isi_c_reg;
              isi_valid_reg <= 1'b1;
            end else begin
              // Consumer still holds the previous sample: keep it stable
              // and record the loss.
              overrun_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_DISARMED;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Rate window
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_reg        <= '0;
      n_reg          <= '0;
      rate_data_reg  <= '0;
      rate_valid_reg <= 1'b0;
    end else begin
      rate_valid_reg <= 1'b0;
      if (!en) begin
        // Restarting from zero aligns the next window with the first
        // enabled cycle after en rises.
        win_reg <= '0;
        n_reg   <= '0;
      end else begin
        win_reg <= win_reg + WIN_LOG2'(1);
        if (win_reg == WIN_LAST) begin
          rate_data_reg  <= n_sat_next;
          rate_valid_reg <= 1'b1;
          n_reg          <= '0;
        end else begin
          n_reg <= n_sat_next;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dec_if.isi_data   = isi_data_reg;
  assign dec_if.isi_valid  = isi_valid_reg;
  assign dec_if.rate_data  = rate_data_reg;
  assign dec_if.rate_valid = rate_valid_reg;
  assign dec_if.overrun    = overrun_reg;

endmodule
